mem_axi_lite_bridge: RTL
========================

# mem_axi_lite_bridge

Data-side bus responder for the MEM stage: it accepts the single-cycle SRAM-style request (ce/we/sel/addr/wdata) that MEM drives and returns read data. It converts each request into one AXI-Lite master transaction and holds the pipeline with `stall_req_o` until the transaction completes. It sits between MEM and the SoC AXI-Lite interconnect.

## Interface
- `AXI_PROT`, 3'b000, value driven on `m_axi_arprot`/`m_axi_awprot`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high (`RST_ENABLE`).
- `mem_ce_i` in 1: request valid; held stable by MEM while stalled.
- `mem_write_en_i` in 1: 1 = write, 0 = read.
- `mem_addr_i` in 32: byte address.
- `mem_sel_i` in 4: byte lanes; bit3 = data[31:24].
- `mem_write_data_i` in 32: write data, already lane-replicated by MEM.
- `flush_i` in 1: exception flush from control.
- `stall_i` in 1: global stall from other pipeline sources; this bridge's own request is excluded.
- `mem_read_data_o` out 32: registered read word.
- `stall_req_o` out 1: pipeline hold request to control.
- `bus_err_o` out 1: one-cycle pulse on a non-OKAY response.
- AXI-Lite master ports, 32-bit data/address:
  - `m_axi_awaddr` out 32, `m_axi_awprot` out 3, `m_axi_awvalid` out 1, `m_axi_awready` in 1
  - `m_axi_wdata` out 32, `m_axi_wstrb` out 4, `m_axi_wvalid` out 1, `m_axi_wready` in 1
  - `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1
  - `m_axi_araddr` out 32, `m_axi_arprot` out 3, `m_axi_arvalid` out 1, `m_axi_arready` in 1
  - `m_axi_rdata` in 32, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1

## Operation
- **States:** IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- **IDLE:**
  - If `mem_ce_i && !flush_i`, latch address `{mem_addr_i[31:2],2'b00}`, strobe = `mem_sel_i`, and wdata.
  - Then go to WR_REQ if `mem_write_en_i`, else RD_ADDR.
- **RD_ADDR:**
  - `arvalid=1`.
  - On `arready`, go to RD_DATA.
- **RD_DATA:**
  - `rready=1`.
  - On `rvalid`, register `rdata` into `mem_read_data_o` and capture `rresp`, then go to DONE.
- **WR_REQ:**
  - `awvalid` and `wvalid` rise together.
  - Each channel drops independently after its own handshake, tracked by `aw_done`/`w_done` flags.
  - When both handshakes are complete (same cycle or either order), go to WR_RESP.
- **WR_RESP:**
  - `bready=1`.
  - On `bvalid`, capture `bresp` and go to DONE.
- **DONE:**
  - `stall_req_o=0`; `bus_err_o=1` for the first DONE cycle only if the captured resp ≠ 2'b00.
  - Stay in DONE while `stall_i=1`; `mem_read_data_o` is held.
  - Go to IDLE when `stall_i=0`. The same request is never re-issued.
- **`stall_req_o`** is combinational: `(IDLE && mem_ce_i && !flush_i) || state ∈ {RD_ADDR, RD_DATA, WR_REQ, WR_RESP}`.
- **Flush:**
  - In IDLE, `flush_i` suppresses the start.
  - In a busy state, the AXI transaction always completes (AXI-Lite cannot be aborted), but the bridge goes to IDLE, not DONE, so there is no `bus_err_o` pulse.
  - `stall_req_o` stays high until completion.
- **AXI address/data outputs** are driven from latched registers, stable while their valid is high. A valid never drops before its ready.
- **Read data** is returned as the full aligned word; MEM performs lane extraction and sign extension.

## Timing
- **Reset:** state=IDLE; all valids/readies=0; `stall_req_o=0`; `bus_err_o=0`; `mem_read_data_o`=0; address, data and strobe registers=0; done flags=0.
  - Reset asserted in any state aborts immediately to IDLE; the AXI side must be reset together with the bridge.
- **Read, zero-wait slave:**
  - Cycle 0 (IDLE, stall high); cycle 1 AR handshake; cycle 2 R handshake; cycle 3 DONE with data valid and stall low.
  - Minimum 3 stall cycles.
- **Write, zero-wait slave:**
  - Cycle 0 IDLE; cycle 1 AW+W; cycle 2 B; cycle 3 DONE.
- **Unbounded slave wait:** the bridge waits indefinitely; there is no timeout.

## Structure
- Shared header `define/axi.vh` holds:
  - state encodings
  - AXI resp codes: OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11
  - `AXI_PROT` default
- The header reuses `RST_ENABLE`, `WRITE_ENABLE` and `ZEROWORD` from `global.vh`.
- Single module, no sub-module; the write channel tracking is two flags inside the FSM.

## Test plan
- **Read:** LW, addr 0x0000_1006, slave returns 0xDEAD_BEEF with zero wait → `araddr=0x0000_1004`, `stall_req_o` high 3 cycles, `mem_read_data_o=0xDEAD_BEEF` in DONE, no re-issue while `mem_ce_i` is still held.
- **SB:** addr 0x10, sel 4'b0100, data 0x5A5A_5A5A; `awready` delayed 2 cycles, `wready` immediate → `wvalid` drops after 1 cycle, `awvalid` after 3, `wstrb=4'b0100`, then one B handshake and DONE.
- **Held in DONE:** `stall_i=1` for 4 cycles during DONE → state holds, `stall_req_o=0`, data held, exactly one AR issued in total.
- **Flush:** `flush_i` pulsed in IDLE with `mem_ce_i=1` → no AXI activity and `stall_req_o=0`. `flush_i` during RD_DATA → R still completes, then IDLE, no DONE.
- **Error response:** `bresp=2'b10` → `bus_err_o` high exactly one cycle in DONE.
- **Mid-transaction reset:** `rst` asserted in WR_RESP → next cycle all outputs at reset values and state IDLE.

Source files
------------

// File: rtl/mem_axi_lite_bridge_pkg.sv
// Shared definitions for the MEM-stage AXI-Lite bridge: reset/write polarities,
// AXI-Lite response codes, default protection bits and the bridge state encoding.
package mem_axi_lite_bridge_pkg;

    localparam logic        RST_ENABLE   = 1'b1;
    localparam logic        WRITE_ENABLE = 1'b1;
    localparam logic [31:0] ZEROWORD     = 32'h0000_0000;

    localparam logic [2:0]  AXI_PROT        = 3'b000;
    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } bridge_state_e;

    // States in which an AXI transaction is outstanding and the pipeline must hold.
    function automatic logic is_busy(input bridge_state_e s);
        return (s == ST_RD_ADDR) || (s == ST_RD_DATA) || (s == ST_WR_REQ) || (s == ST_WR_RESP);
    endfunction

endpackage

// File: rtl/mem_axi_lite_bridge.sv
// MEM-stage data-side responder: turns one SRAM-style request into one AXI-Lite
// transaction and holds the pipeline until the response has been taken.
//
// state    | meaning
// IDLE     | waiting for mem_ce_i; start is combinational so stall rises in the same cycle
// RD_ADDR  | AR channel valid, waiting for arready
// RD_DATA  | R channel ready, waiting for rvalid
// WR_REQ   | AW and W valid, each dropping after its own handshake
// WR_RESP  | B channel ready, waiting for bvalid
// DONE     | result available, pipeline released; held while stall_i is high
module mem_axi_lite_bridge
    import mem_axi_lite_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        mem_ce_i,
    input  logic        mem_write_en_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_write_data_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic [31:0] mem_read_data_o,
    output logic        stall_req_o,
    output logic        bus_err_o,

    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    bridge_state_e r_state;
    bridge_state_e w_next;
    bridge_state_e w_finish;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_strb;
    logic [31:0] r_rdata;
    logic [1:0]  r_resp;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_flushed;
    logic        r_first_done;

    logic        w_start;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_unused_addr_lsb;

    assign w_start           = mem_ce_i && !flush_i;
    assign w_aw_hs           = m_axi_awvalid && m_axi_awready;
    assign w_w_hs            = m_axi_wvalid && m_axi_wready;
    assign w_unused_addr_lsb = ^mem_addr_i[1:0];

    // A flushed transaction still runs to completion on the bus but never reports.
    assign w_finish = (r_flushed || flush_i) ? ST_IDLE : ST_DONE;

    always_comb begin
        w_next        = r_state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next = (mem_write_en_i == WRITE_ENABLE) ? ST_WR_REQ : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) w_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) w_next = w_finish;
            end
            ST_WR_REQ: begin
                m_axi_awvalid = !r_aw_done;
                m_axi_wvalid  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) w_next = w_finish;
            end
            ST_DONE: begin
                if (!stall_i) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state      <= ST_IDLE;
            r_addr       <= ZEROWORD;
            r_wdata      <= ZEROWORD;
            r_strb       <= 4'b0000;
            r_rdata      <= ZEROWORD;
            r_resp       <= AXI_RESP_OKAY;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_flushed    <= 1'b0;
            r_first_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_first_done <= (w_next == ST_DONE) && (r_state != ST_DONE);
            if (is_busy(r_state) && flush_i) r_flushed <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr    <= {mem_addr_i[31:2], 2'b00};
                        r_strb    <= mem_sel_i;
                        r_wdata   <= mem_write_data_i;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_flushed <= 1'b0;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        r_rdata <= m_axi_rdata;
                        r_resp  <= m_axi_rresp;
                    end
                end
                ST_WR_REQ: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) r_resp <= m_axi_bresp;
                end
                default: ;
            endcase
        end
    end

    // Gated by rst so the hold request is already low while reset is applied.
    assign stall_req_o = (rst != RST_ENABLE) &&
                         (((r_state == ST_IDLE) && w_start) || is_busy(r_state));
    assign bus_err_o   = (r_state == ST_DONE) && r_first_done && (r_resp != AXI_RESP_OKAY);

    assign mem_read_data_o = r_rdata;
    assign m_axi_awaddr    = r_addr;
    assign m_axi_araddr    = r_addr;
    assign m_axi_wdata     = r_wdata;
    assign m_axi_wstrb     = r_strb;
    assign m_axi_awprot    = AXI_PROT;
    assign m_axi_arprot    = AXI_PROT;

endmodule
